// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: datapath width, PC step, bubble encoding
// and the fetch FSM state type.
package fetch_unit_pkg;
  localparam int N = 32;
  localparam logic [N-1:0] PC_STEP = 32'd4;
  localparam logic [N-1:0] INSTR_BUBBLE = '0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;
endpackage

// File: rtl/fetch_out_buf.sv
// IF/ID output register plus one-entry skid; refills the same edge it is consumed.
// No added latency; holds contents while freeze is high, the skid absorbs one response.
module fetch_out_buf
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         freeze,
  input  logic         flush,
  input  logic         load,
  input  logic [N-1:0] loadPc,
  input  logic [N-1:0] loadInstr,
  output logic         instrValid,
  output logic [N-1:0] pcOut,
  output logic [N-1:0] instructionOut,
  output logic         skidNext
);
  logic         skidValid;
  logic [N-1:0] skidPc;
  logic [N-1:0] skidInstr;
  logic         outFree;

  assign outFree  = ~instrValid | ~freeze;
  // Skid is occupied after this edge only if the output stays held and has something to park.
  assign skidNext = ~flush & ~outFree & (skidValid | load);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instrValid     <= 1'b0;
      pcOut          <= '0;
      instructionOut <= INSTR_BUBBLE;
      skidValid      <= 1'b0;
      skidPc         <= '0;
      skidInstr      <= '0;
    end else if (flush) begin
      instrValid     <= 1'b0;
      instructionOut <= INSTR_BUBBLE;
      skidValid      <= 1'b0;
    end else if (outFree) begin
      if (skidValid) begin
        instrValid     <= 1'b1;
        pcOut          <= skidPc;
        instructionOut <= skidInstr;
        skidValid      <= 1'b0;
      end else if (load) begin
        instrValid     <= 1'b1;
        pcOut          <= loadPc;
        instructionOut <= loadInstr;
      end else begin
        instrValid     <= 1'b0;
        instructionOut <= INSTR_BUBBLE;
      end
    end else if (load) begin
      skidValid <= 1'b1;
      skidPc    <= loadPc;
      skidInstr <= loadInstr;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request FSM and redirect kill handling.
// Response lands in IF/ID on the sampling edge; no new request while the skid is full.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [N-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         freeze,
  input  logic         redirect,
  input  logic [N-1:0] redirectPc,
  output logic         imemReq,
  output logic [N-1:0] imemAddr,
  input  logic         imemGnt,
  input  logic         imemRvalid,
  input  logic [N-1:0] imemRdata,
  output logic         instrValid,
  output logic [N-1:0] pcOut,
  output logic [N-1:0] instructionOut
);
  fetch_state_t state, stateNext;
  logic [N-1:0] fetchPc, fetchPcNext;
  logic [N-1:0] reqPc, reqPcNext;
  logic         kill, killNext;
  logic         load;
  logic         skidNext;
  logic [N-1:0] redirTgt;

  assign redirTgt = {redirectPc[N-1:2], 2'b00};
  assign imemReq  = (state == REQ);
  assign imemAddr = reqPc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      fetchPc <= RESET_PC;
      reqPc   <= RESET_PC;
      kill    <= 1'b0;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
      reqPc   <= reqPcNext;
      kill    <= killNext;
    end
  end

  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    reqPcNext   = reqPc;
    killNext    = kill;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          stateNext   = REQ;
          reqPcNext   = redirTgt;
          fetchPcNext = redirTgt;
        end else if (!skidNext) begin
          stateNext = REQ;
          reqPcNext = fetchPc;
        end
      end
      REQ: begin
        // The held address may be wrong-path; its response is killed, never the PC advanced.
        if (redirect) begin
          fetchPcNext = redirTgt;
          killNext    = 1'b1;
        end else if (imemGnt && !kill) begin
          fetchPcNext = reqPc + PC_STEP;
        end
        if (imemGnt) stateNext = WAIT;
      end
      WAIT: begin
        if (imemRvalid) begin
          killNext = 1'b0;
          if (redirect) begin
            stateNext   = REQ;
            reqPcNext   = redirTgt;
            fetchPcNext = redirTgt;
          end else if (kill) begin
            stateNext = REQ;
            reqPcNext = fetchPc;
          end else begin
            load = 1'b1;
            if (skidNext) begin
              stateNext = IDLE;
            end else begin
              stateNext = REQ;
              reqPcNext = fetchPc;
            end
          end
        end else if (redirect) begin
          killNext    = 1'b1;
          fetchPcNext = redirTgt;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  fetch_out_buf u_out_buf (
    .clk           (clk),
    .rstn          (rstn),
    .freeze        (freeze),
    .flush         (redirect),
    .load          (load),
    .loadPc        (reqPc),
    .loadInstr     (imemRdata),
    .instrValid    (instrValid),
    .pcOut         (pcOut),
    .instructionOut(instructionOut),
    .skidNext      (skidNext)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem, cycle table for streaming/freeze,
// hand sequences for redirect and reset corners, scoreboard of consumed PCs.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        freeze = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic [31:0] pcOut;
  logic [31:0] instructionOut;

  logic        gnt_en = 1'b1;
  int          lat = 1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sbq[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .freeze(freeze), .redirect(redirect), .redirectPc(redirectPc),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt), .imemRvalid(imemRvalid),
    .imemRdata(imemRdata), .instrValid(instrValid), .pcOut(pcOut), .instructionOut(instructionOut)
  );

  assign imemGnt = gnt_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC001_D00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Instruction memory: fixed latency per request, reset by the same rstn.
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= 1'b0; cnt <= 0; paddr <= '0; imemRvalid <= 1'b0; imemRdata <= '0;
    end else begin
      imemRvalid <= 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imemRvalid <= 1'b1; imemRdata <= mem_word(paddr); pend <= 1'b0;
        end else cnt <= cnt - 1;
      end
      if (imemReq && imemGnt) begin
        if (lat <= 1) begin
          imemRvalid <= 1'b1; imemRdata <= mem_word(imemAddr);
        end else begin
          pend <= 1'b1; cnt <= lat - 1; paddr <= imemAddr;
        end
      end
    end
  end

  // Scoreboard: each instruction consumed by IF/ID must match the next expected PC.
  always @(negedge clk) begin
    if (rstn) begin
      chk("one_outstanding", {31'b0, imemReq && (pend || imemRvalid)}, 32'h0);
      if (instrValid && !freeze && !redirect && sbq.size() > 0) begin
        logic [31:0] e;
        e = sbq.pop_front();
        chk("sb_pc", pcOut, e);
        chk("sb_instr", instructionOut, mem_word(e));
      end
      if (!instrValid) chk("bubble", instructionOut, 32'h0);
    end
  end

  typedef struct {
    logic        frz;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(input logic f, input logic r, input logic [31:0] a,
                              input logic v, input logic [31:0] p);
    vec_t x;
    x.frz = f; x.req = r; x.addr = a; x.iv = v; x.pc = p;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imemReq}, 32'h0);
    chk({tag, "_addr"}, imemAddr, 32'h0);
    chk({tag, "_iv"}, {31'b0, instrValid}, 32'h0);
    chk({tag, "_pc"}, pcOut, 32'h0);
    chk({tag, "_instr"}, instructionOut, 32'h0);
  endtask

  task automatic do_reset();
    rstn = 1'b0; freeze = 1'b0; redirect = 1'b0; redirectPc = '0; gnt_en = 1'b1; lat = 1;
    #1;
    chk_reset_outputs("reset");
    sbq.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drain(input string nm, input int budget);
    for (int n = 0; n < budget && sbq.size() != 0; n++) @(posedge clk);
    chk(nm, sbq.size(), 32'h0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_io(input string nm, input logic req, input logic [31:0] addr, input logic iv);
    chk({nm, "_req"}, {31'b0, imemReq}, {31'b0, req});
    chk({nm, "_addr"}, imemAddr, addr);
    chk({nm, "_iv"}, {31'b0, instrValid}, {31'b0, iv});
  endtask

  initial begin
    // Edge-by-edge trace after reset release, 1-cycle memory, grant always high;
    // freeze held across edges 8..13 while PC 0x8 is presented.
    tbl[0]  = mk(0, 1, 32'h00, 0, 32'h00);
    tbl[1]  = mk(0, 0, 32'h00, 0, 32'h00);
    tbl[2]  = mk(0, 1, 32'h04, 1, 32'h00);
    tbl[3]  = mk(0, 0, 32'h04, 0, 32'h00);
    tbl[4]  = mk(0, 1, 32'h08, 1, 32'h04);
    tbl[5]  = mk(0, 0, 32'h08, 0, 32'h00);
    tbl[6]  = mk(0, 1, 32'h0C, 1, 32'h08);
    tbl[7]  = mk(1, 0, 32'h0C, 1, 32'h08);
    tbl[8]  = mk(1, 0, 32'h0C, 1, 32'h08);
    tbl[9]  = mk(1, 0, 32'h0C, 1, 32'h08);
    tbl[10] = mk(1, 0, 32'h0C, 1, 32'h08);
    tbl[11] = mk(1, 0, 32'h0C, 1, 32'h08);
    tbl[12] = mk(1, 0, 32'h0C, 1, 32'h08);
    tbl[13] = mk(0, 1, 32'h10, 1, 32'h0C);
    tbl[14] = mk(0, 0, 32'h10, 0, 32'h00);
    tbl[15] = mk(0, 1, 32'h14, 1, 32'h10);

    do_reset();
    for (int i = 0; i < 5; i++) sbq.push_back(32'(i * 4));
    for (int i = 0; i < 16; i++) begin
      freeze = tbl[i].frz;
      step();
      chk_io($sformatf("vec%0d", i + 1), tbl[i].req, tbl[i].addr, tbl[i].iv);
      if (tbl[i].iv) begin
        chk($sformatf("vec%0d_pc", i + 1), pcOut, tbl[i].pc);
        chk($sformatf("vec%0d_instr", i + 1), instructionOut, mem_word(tbl[i].pc));
      end else begin
        chk($sformatf("vec%0d_instr", i + 1), instructionOut, 32'h0);
      end
    end
    freeze = 1'b0;
    drain("stream_drain", 20);

    // Redirect in WAIT; the in-flight response arrives two cycles later and is dropped.
    do_reset();
    lat = 3;
    step(); chk_io("rw_e1", 1'b1, 32'h0, 1'b0);
    step(); chk_io("rw_e2", 1'b0, 32'h0, 1'b0);
    redirect = 1'b1; redirectPc = 32'h100;
    step(); redirect = 1'b0; lat = 1;
    chk_io("rw_e3", 1'b0, 32'h0, 1'b0);
    sbq.push_back(32'h100); sbq.push_back(32'h104);
    step(); chk_io("rw_e4", 1'b0, 32'h0, 1'b0);
    step(); chk_io("rw_e5", 1'b1, 32'h100, 1'b0);
    drain("rw_drain", 40);

    // Redirect to a misaligned target in REQ while the grant is withheld.
    do_reset();
    gnt_en = 1'b0;
    step(); chk_io("rq_e1", 1'b1, 32'h0, 1'b0);
    redirect = 1'b1; redirectPc = 32'h203;
    step(); redirect = 1'b0;
    chk_io("rq_e2", 1'b1, 32'h0, 1'b0);
    step(); chk_io("rq_e3", 1'b1, 32'h0, 1'b0);
    step(); chk_io("rq_e4", 1'b1, 32'h0, 1'b0);
    gnt_en = 1'b1;
    sbq.push_back(32'h200); sbq.push_back(32'h204);
    step(); chk_io("rq_e5", 1'b0, 32'h0, 1'b0);
    step(); chk_io("rq_e6", 1'b1, 32'h200, 1'b0);
    drain("rq_drain", 40);

    // Redirect and freeze together: the frozen instruction is still flushed.
    do_reset();
    step(); step(); step();
    chk("rf_pre_iv", {31'b0, instrValid}, 32'h1);
    chk("rf_pre_pc", pcOut, 32'h0);
    freeze = 1'b1; redirect = 1'b1; redirectPc = 32'h40;
    step(); freeze = 1'b0; redirect = 1'b0;
    chk("rf_iv", {31'b0, instrValid}, 32'h0);
    chk("rf_instr", instructionOut, 32'h0);
    sbq.push_back(32'h40); sbq.push_back(32'h44);
    step(); chk_io("rf_e5", 1'b1, 32'h40, 1'b0);
    drain("rf_drain", 40);

    // Asynchronous reset while a request is outstanding, then a clean restart.
    do_reset();
    step(); step(); step();
    freeze = 1'b1;
    step(); chk_io("ar_wait", 1'b0, 32'h4, 1'b1);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("ar_async");
    freeze = 1'b0;
    @(negedge clk); rstn = 1'b1;
    sbq.push_back(32'h0); sbq.push_back(32'h4); sbq.push_back(32'h8);
    step(); chk_io("ar_e1", 1'b1, 32'h0, 1'b0);
    drain("ar_drain", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined core. It owns the program counter, issues one instruction-memory request at a time over a request/grant/response handshake, and absorbs redirects from the branch-resolution logic. It feeds fetched instructions, with their PCs, into the IF/ID pipeline register, and holds them while the downstream freeze is asserted.

## Interface
- RESET_PC, 32'h0000_0000: PC of the first fetch after reset.
- N (from `defines`), 32: datapath, PC and instruction width.

- clk  in  1  core clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- freeze  in  1  IF/ID hold; the output instruction is not consumed in this cycle.
- redirect  in  1  taken branch or jump; wrong-path work is flushed.
- redirectPc  in  N  redirect target; bits [1:0] are forced to 0.
- imemReq  out  1  request valid.
- imemAddr  out  N  request address; stable while imemReq=1 and no grant.
- imemGnt  in  1  request accepted in this cycle.
- imemRvalid  in  1  response valid; cannot be back-pressured.
- imemRdata  in  N  response instruction.
- instrValid  out  1  pcOut/instructionOut hold a valid instruction.
- pcOut  out  N  PC of the presented instruction; connects to IF/ID pcIn.
- instructionOut  out  N  presented instruction; '0 when instrValid=0.

## Operation
- Registers:
  - fetchPc: next PC to request.
  - reqPc: PC of the in-flight request; drives imemAddr.
  - output register: instrValid, pcOut, instructionOut.
  - skid register: skidValid, skidPc, skidInstr.
  - kill flag.
- Consumption: at a rising edge with instrValid=1 and freeze=0, the output register is consumed.
  - The output register refills from the skid register, or from imemRvalid, in that order.
  - Otherwise the output register empties.
- States:
  - IDLE: no request.
    - Moves to REQ when skidValid=0 (after the edge), loading reqPc<=fetchPc.
  - REQ: imemReq=1, imemAddr=reqPc.
    - On imemGnt: fetchPc<=reqPc+4 (modulo 2^N), then WAIT.
  - WAIT: awaiting imemRvalid.
    - On imemRvalid, the response is placed:
      - into the output register if it is empty or consumed in this edge;
      - otherwise into the skid register.
    - Next state is REQ (reqPc<=fetchPc) if the skid register ends up empty; otherwise IDLE.
- Exactly one request is outstanding at a time. The skid register never overflows: no request is issued while skidValid=1.
- Redirect: at the edge, it has priority over all other events, including freeze.
  - instrValid<=0 and skidValid<=0; fetchPc<=redirectPc.
  - In IDLE: the next state is REQ with reqPc<=redirectPc.
  - In REQ: the address is held. kill<=1 and the state stays REQ until the grant, then moves to WAIT.
  - In WAIT without imemRvalid: kill<=1 and the state stays WAIT.
  - In WAIT with imemRvalid: the response is discarded and the state moves to REQ with reqPc<=redirectPc.
  - In REQ or WAIT, fetchPc is not incremented by a grant in the same cycle.
- Killed response: imemRvalid while kill=1 is dropped and clears kill. The state moves to REQ with reqPc<=fetchPc.
- A second redirect while kill=1 only updates fetchPc.

## Timing
- Reset (asynchronous):
  - state=IDLE, fetchPc=RESET_PC, reqPc=RESET_PC.
  - instrValid=0, pcOut=0, instructionOut=0.
  - skidValid=0, kill=0.
  - imemReq=0, imemAddr=RESET_PC.
- Reset asserted mid-transaction abandons the request. The memory is reset by the same rstn.
- After rstn rises:
  - First edge: IDLE→REQ.
  - imemReq is high from cycle 1.
- Latency:
  - A grant in cycle k allows imemRvalid in cycle k+1 at the earliest.
  - instrValid rises on the edge that samples imemRvalid.
- Peak throughput: 1 instruction per 2 cycles with a 1-cycle memory.
- Redirect sampled at edge t: the request for the redirect target is issued no earlier than cycle t+1. No wrong-path instruction is presented after edge t.

## Structure
- `defines` gains:
  - `fetch_state_t` (IDLE, REQ, WAIT);
  - `PC_STEP` = 4;
  - `INSTR_BUBBLE` = '0.
- Sub-module `fetch_out_buf` contains the output register and the skid register, with load, consume and flush controls. The top-level holds the FSM, the PCs and kill.

## Test plan
- Reset release with memory latency 1 and grant always high:
  - instrValid first rises 2 edges after imemReq rises, pcOut=0x0;
  - then PCs 0x4, 0x8 follow, one every 2 cycles.
- freeze held for 6 cycles during streaming:
  - pcOut stays fixed and the skid register fills once;
  - imemReq stays low while skidValid=1;
  - after release, the instructions at 0x8 and 0xC appear in order with no loss.
- redirect to 0x100 in WAIT, rvalid 2 cycles later:
  - the response is dropped;
  - the next imemAddr is 0x100;
  - no instruction from the old path is presented.
- redirect to 0x203 in REQ with imemGnt low for 3 cycles:
  - imemAddr is held until the grant;
  - that response is killed;
  - the next request address is 0x200.
- redirect and freeze in the same cycle:
  - instrValid=0 and instructionOut=0 after the edge.
- rstn dropped while in WAIT:
  - all outputs go to their reset values immediately (asynchronously);
  - a clean restart at RESET_PC follows.
